// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types and widths for the unified memory arbiter
package unified_mem_arbiter_pkg;

  localparam int STREAK_W = 4;
  localparam int WDOG_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbState_t;

endpackage

// File: rtl/unified_mem_arbiter_wdog.sv
// rtl/unified_mem_arbiter_wdog.sv - wait-cycle watchdog with sticky timeout flag
module mem_wdog_timer
  import unified_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incEn,
  output logic err
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  logic [WDOG_W-1:0] waitCount;
  logic [WDOG_W-1:0] countNext;

  // Next count: clear wins over increment; saturate so a very long stall never wraps.
  always_comb begin
    countNext = waitCount;
    if (clear) begin
      countNext = '0;
    end else if (incEn && (waitCount != '1)) begin
      countNext = waitCount + WDOG_W'(1);
    end
  end

  // Count register; err latches on the increment that reaches the limit and holds until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCount <= '0;
      err       <= 1'b0;
    end else begin
      waitCount <= countNext;
      if (incEn && !clear && (countNext == LIMIT)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter in front of a single-ported variable-latency memory
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arbState_t           state;
  arbState_t           stateNext;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streakNext;
  logic                memReqNext;
  logic                memWeNext;
  logic [31:0]         memAddrNext;
  logic [31:0]         memWdataNext;
  logic                busy;
  logic                decisionEdge;
  logic                grantData;
  logic                grantFetch;

  // A decision is taken on every idle edge and on the edge that retires the current access.
  assign busy         = (state != IDLE);
  assign decisionEdge = !busy || mem_ready;

  // Data has priority unless it has already won STREAK_MAX times in a row over a waiting fetch.
  assign grantData  = decisionEdge && d_req && (!if_req || (streak < STREAK_MAX));
  assign grantFetch = decisionEdge && !grantData && if_req;

  // Completion strobes are combinational so the requester can advance on the same edge.
  assign if_valid = (state == BUSY_I) && mem_ready;
  assign d_valid  = (state == BUSY_D) && mem_ready;
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state, next memory command and streak update; everything holds while waiting.
  always_comb begin
    stateNext    = state;
    streakNext   = streak;
    memReqNext   = mem_req;
    memWeNext    = mem_we;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    if (decisionEdge) begin
      if (grantData) begin
        stateNext    = BUSY_D;
        memReqNext   = 1'b1;
        memWeNext    = d_we;
        memAddrNext  = d_addr;
        memWdataNext = d_wdata;
        if (if_req) begin
          if (streak < STREAK_MAX) begin
            streakNext = streak + STREAK_W'(1);
          end
        end else begin
          streakNext = '0;
        end
      end else if (grantFetch) begin
        stateNext    = BUSY_I;
        memReqNext   = 1'b1;
        memWeNext    = 1'b0;
        memAddrNext  = if_addr;
        memWdataNext = '0;
        streakNext   = '0;
      end else begin
        stateNext  = IDLE;
        memReqNext = 1'b0;
        memWeNext  = 1'b0;
      end
    end
  end

  // Registered memory command and streak counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      streak    <= '0;
    end else begin
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      streak    <= streakNext;
    end
  end

  mem_wdog_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uWdog (
    .clk  (clk),
    .reset(reset),
    .clear(decisionEdge),
    .incEn(busy && !mem_ready),
    .err  (err)
  );

endmodule
